key_entry_buffer: RTL and testbench
===================================

# key_entry_buffer

Parametrised keypad entry buffer for the alarm clock datapath. It sits between the keypad decoder/FSM and the alarm and time registers. It shifts in decimal key digits one position per strobe, and adds backspace, clear, an inactivity timeout, and a validated commit handshake with an entry-count tracker. It supersedes the fixed four-digit key shift register.

## Interface
Parameters:
- DIGITS, 4: number of BCD digit slots (2..8).
- KEY_W, 4: width of one key code and one digit slot.
- TIMEOUT_CYC, 0: idle cycles before auto-clear; 0 disables the timeout.
- CHECK_TIME, 1: enables HH:MM range check on commit; legal only with DIGITS == 4.

Ports (CW = $clog2(DIGITS+1)):
- clock  in  1  single system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- shift  in  1  one-cycle strobe: shift key into digit 0.
- key  in  KEY_W  key code, sampled when shift = 1.
- backspace  in  1  strobe: drop the most recent digit.
- clear  in  1  strobe: empty the buffer.
- commit  in  1  strobe: request transfer of the entry.
- key_buffer  out  DIGITS*KEY_W  digit i at bits [i*KEY_W +: KEY_W]; digit 0 = ls_min, digit 3 = ms_hr.
- count  out  CW  number of digits entered, 0..DIGITS.
- full  out  1  count == DIGITS.
- commit_value  out  DIGITS*KEY_W  last successfully committed entry.
- commit_ok  out  1  one-cycle pulse: commit accepted.
- commit_err  out  1  one-cycle pulse: commit rejected.
- timeout  out  1  one-cycle pulse: buffer auto-cleared.

## Operation
- Reset state: key_buffer, count, commit_value and the idle counter all 0. full, commit_ok, commit_err and timeout all 0. FSM in EMPTY.
- FSM states:
  - EMPTY: count = 0.
  - PARTIAL: 0 < count < DIGITS.
  - FULL: count = DIGITS.
  - The state is derived from count after each update.
- Event priority per cycle: reset > clear > commit > backspace > shift. Only the highest-priority asserted event acts; lower ones are discarded.
- shift with key <= 9:
  - Digit i+1 takes digit i. Digit 0 takes key. Digit DIGITS-1 is discarded.
  - count increments and saturates at DIGITS. In FULL the buffer rolls and keeps the last DIGITS keys.
- shift with key > 9: ignored. No change to the buffer, count or idle counter.
- backspace:
  - Digit i takes digit i+1. Digit DIGITS-1 takes 0.
  - count decrements. In EMPTY it is a no-op.
- clear: buffer and count go to 0. No pulse is raised.
- commit:
  - If count == DIGITS and the check passes: commit_value takes key_buffer, commit_ok pulses, and buffer and count clear.
  - Otherwise commit_err pulses and the buffer is unchanged.
  - The check passes when CHECK_TIME = 0, or when ms_hr <= 2, ms_min <= 5, and (ms_hr != 2 or ls_hr <= 3).
- Slots at index >= count are always 0.
- Idle counter:
  - Cleared by any accepted event (shift with a valid key, backspace, clear, commit) and while in EMPTY.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYC-1 in PARTIAL or FULL, the buffer and count clear and timeout pulses. It does not wrap past this value.
  - An accepted event in the same cycle takes precedence over the timeout.

## Timing
- All outputs are registered. An event sampled on edge N is visible after edge N; key_buffer, count and full update with one cycle of latency.
- commit_ok, commit_err and timeout are high for exactly one cycle, on the cycle after the triggering edge. At most one of them is high in any cycle.
- Back-to-back strobes on consecutive cycles are each processed; no dead cycle is needed.
- Reset asserted mid-entry clears everything on the next edge, including a pending pulse. Pulses read 0 the cycle after reset.
- The idle counter width is $clog2(TIMEOUT_CYC+1), and it saturates.

## Test plan
- Entry: after reset, shift keys 1, 2, 3, 0 on consecutive cycles -> key_buffer = 16'h1230, count = 4, full = 1.
- Rolling entry: continue from 16'h1230 with shift key 7 -> key_buffer = 16'h2307, count = 4. Then shift key 4'hB -> no change.
- Backspace: from 16'h2307, backspace twice -> 16'h0023, count = 2. Two further backspaces -> 0, count = 0. A fifth backspace -> no-op.
- Commit accept: enter 2, 3, 5, 9 -> commit -> commit_ok for one cycle, commit_value = 16'h2359, key_buffer = 0.
- Commit reject:
  - Enter 2, 4, 0, 0 -> commit -> commit_err, buffer held at 16'h2400.
  - Enter 1, 2, 6, 0 -> commit -> commit_err.
  - Enter 3 digits -> commit -> commit_err.
- Timeout and priority:
  - With TIMEOUT_CYC = 8, enter one key and idle 7 cycles -> timeout pulse, buffer = 0, count = 0.
  - clear and shift asserted in the same cycle -> buffer = 0.
  - Reset asserted during a commit cycle -> no commit_ok, all outputs 0.

Source files
------------

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: shifts BCD key digits in, supports backspace, clear,
// inactivity auto-clear and a range-checked commit into commit_value.
//
// state     | meaning
// ----------+--------------------------------------
// S_EMPTY   | no digits entered (count == 0)
// S_PARTIAL | some digits entered (0 < count < DIGITS)
// S_FULL    | every slot holds a digit (count == DIGITS)
module key_entry_buffer #(
    parameter int DIGITS      = 4,
    parameter int KEY_W       = 4,
    parameter int TIMEOUT_CYC = 0,
    parameter bit CHECK_TIME  = 1,
    localparam int CW         = $clog2(DIGITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    shift,
    input  logic [KEY_W-1:0]        key,
    input  logic                    backspace,
    input  logic                    clear,
    input  logic                    commit,
    output logic [DIGITS*KEY_W-1:0] key_buffer,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic [DIGITS*KEY_W-1:0] commit_value,
    output logic                    commit_ok,
    output logic                    commit_err,
    output logic                    timeout
);

    localparam int BW = DIGITS * KEY_W;
    localparam int IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   entry_q, entry_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [BW-1:0]   cv_q, cv_nxt;
    logic [IW-1:0]   idle_q, idle_nxt;
    logic            ok_q, ok_nxt;
    logic            err_q, err_nxt;
    logic            tmo_q, tmo_nxt;
    logic            time_ok;
    logic            key_valid;
    logic            tmo_hit;
    logic            accepted;

    // Digit 3 = ms_hr, 2 = ls_hr, 1 = ms_min, 0 = ls_min.
    if (CHECK_TIME && DIGITS >= 4) begin : g_time_check
        logic [KEY_W-1:0] ms_hr;
        logic [KEY_W-1:0] ls_hr;
        logic [KEY_W-1:0] ms_min;
        assign ms_hr   = entry_q[3*KEY_W +: KEY_W];
        assign ls_hr   = entry_q[2*KEY_W +: KEY_W];
        assign ms_min  = entry_q[1*KEY_W +: KEY_W];
        assign time_ok = (32'(ms_hr) <= 32'd2) && (32'(ms_min) <= 32'd5)
                         && ((32'(ms_hr) != 32'd2) || (32'(ls_hr) <= 32'd3));
    end else begin : g_no_time_check
        assign time_ok = 1'b1;
    end

    // Fires on the increment that would bring the idle count to TIMEOUT_CYC-1.
    if (TIMEOUT_CYC > 0) begin : g_timeout
        assign tmo_hit = (32'(idle_q) + 32'd2) >= 32'(TIMEOUT_CYC);
    end else begin : g_no_timeout
        assign tmo_hit = 1'b0;
    end

    assign key_valid = 32'(key) <= 32'd9;

    always_comb begin
        entry_nxt = entry_q;
        cnt_nxt   = cnt_q;
        cv_nxt    = cv_q;
        idle_nxt  = idle_q;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        accepted  = 1'b1;
        state_nxt = state;

        if (clear) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
        end else if (commit) begin
            if (cnt_q == CW'(DIGITS) && time_ok) begin
                cv_nxt    = entry_q;
                ok_nxt    = 1'b1;
                entry_nxt = '0;
                cnt_nxt   = '0;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (backspace) begin
            if (cnt_q != '0) begin
                entry_nxt = {{KEY_W{1'b0}}, entry_q[BW-1:KEY_W]};
                cnt_nxt   = cnt_q - CW'(1);
            end
        end else if (shift && key_valid) begin
            entry_nxt = {entry_q[BW-KEY_W-1:0], key};
            if (cnt_q != CW'(DIGITS)) begin
                cnt_nxt = cnt_q + CW'(1);
            end
        end else begin
            accepted = 1'b0;
        end

        if (accepted || state == S_EMPTY) begin
            idle_nxt = '0;
        end else if (tmo_hit) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
            tmo_nxt   = 1'b1;
            idle_nxt  = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_nxt = idle_q + IW'(1);
        end

        if (cnt_nxt == '0) begin
            state_nxt = S_EMPTY;
        end else if (cnt_nxt == CW'(DIGITS)) begin
            state_nxt = S_FULL;
        end else begin
            state_nxt = S_PARTIAL;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_EMPTY;
            entry_q <= '0;
            cnt_q   <= '0;
            cv_q    <= '0;
            idle_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            entry_q <= entry_nxt;
            cnt_q   <= cnt_nxt;
            cv_q    <= cv_nxt;
            idle_q  <= idle_nxt;
            ok_q    <= ok_nxt;
            err_q   <= err_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    assign key_buffer   = entry_q;
    assign count        = cnt_q;
    assign full         = (state == S_FULL);
    assign commit_value = cv_q;
    assign commit_ok    = ok_q;
    assign commit_err   = err_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer: the driver queues expected states and
// pulses with their cycle stamps; a negedge monitor pops and compares them.
module tb_key_entry_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        shift;
    logic [3:0]  key;
    logic        backspace;
    logic        clear;
    logic        commit;
    logic [15:0] key_buffer;
    logic [2:0]  count;
    logic        full;
    logic [15:0] commit_value;
    logic        commit_ok;
    logic        commit_err;
    logic        timeout;

    key_entry_buffer #(
        .DIGITS(4),
        .KEY_W(4),
        .TIMEOUT_CYC(8),
        .CHECK_TIME(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .shift(shift),
        .key(key),
        .backspace(backspace),
        .clear(clear),
        .commit(commit),
        .key_buffer(key_buffer),
        .count(count),
        .full(full),
        .commit_value(commit_value),
        .commit_ok(commit_ok),
        .commit_err(commit_err),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [15:0] kb;
        logic [2:0]  cnt;
        logic        full;
        logic [15:0] cv;
    } st_t;

    typedef struct {
        int          stamp;
        logic [2:0]  kind;
        logic [15:0] val;
    } pe_t;

    localparam logic [2:0] K_OK  = 3'b001;
    localparam logic [2:0] K_ERR = 3'b010;
    localparam logic [2:0] K_TMO = 3'b100;

    st_t         sq[$];
    pe_t         pq[$];
    int          checks = 0;
    int          errors = 0;
    int          last_stamp = 0;
    bit          mon_en = 1'b0;
    logic [15:0] cv_model = 16'h0000;

    task automatic step(input logic rst, input logic sh, input logic [3:0] k,
                        input logic bs, input logic clr, input logic cm);
        @(negedge clock);
        last_stamp = cyc + 1;
        reset     = rst;
        shift     = sh;
        key       = k;
        backspace = bs;
        clear     = clr;
        commit    = cm;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        shift     = 1'b0;
        key       = 4'h0;
        backspace = 1'b0;
        clear     = 1'b0;
        commit    = 1'b0;
    endtask

    task automatic expect_st(input int stamp, input logic [15:0] kb, input logic [2:0] c);
        st_t e;
        e.stamp = stamp;
        e.kb    = kb;
        e.cnt   = c;
        e.full  = (c == 3'd4);
        e.cv    = cv_model;
        sq.push_back(e);
    endtask

    task automatic expect_pulse(input int stamp, input logic [2:0] kind, input logic [15:0] val);
        pe_t p;
        p.stamp = stamp;
        p.kind  = kind;
        p.val   = val;
        pq.push_back(p);
    endtask

    task automatic sh(input logic [3:0] k, input logic [15:0] kb, input logic [2:0] c);
        step(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0);
        expect_st(last_stamp, kb, c);
    endtask

    task automatic bs(input logic [15:0] kb, input logic [2:0] c);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        expect_st(last_stamp, kb, c);
    endtask

    task automatic clr();
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        expect_st(last_stamp, 16'h0000, 3'd0);
    endtask

    st_t        me;
    pe_t        mp;
    logic [2:0] got;

    always @(negedge clock) begin
        if (mon_en) begin
            while (sq.size() > 0 && sq[0].stamp <= cyc) begin
                me = sq.pop_front();
                checks++;
                if (me.stamp != cyc || key_buffer !== me.kb || count !== me.cnt
                    || full !== me.full || commit_value !== me.cv) begin
                    errors++;
                    $display("FAIL state@%0d: got kb=%h cnt=%0d full=%b cv=%h, want kb=%h cnt=%0d full=%b cv=%h (cyc %0d)",
                             me.stamp, key_buffer, count, full, commit_value,
                             me.kb, me.cnt, me.full, me.cv, cyc);
                end
            end
            got = {timeout, commit_err, commit_ok};
            while (pq.size() > 0 && pq[0].stamp < cyc) begin
                mp = pq.pop_front();
                checks++;
                errors++;
                $display("FAIL pulse_missing@%0d: got none, want kind=%b", mp.stamp, mp.kind);
            end
            if (pq.size() > 0 && pq[0].stamp == cyc) begin
                mp = pq.pop_front();
                checks++;
                if (got !== mp.kind || (mp.kind == K_OK && commit_value !== mp.val)) begin
                    errors++;
                    $display("FAIL pulse@%0d: got kind=%b cv=%h, want kind=%b cv=%h",
                             mp.stamp, got, commit_value, mp.kind, mp.val);
                end
            end else if (got !== 3'b000) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse@%0d: got kind=%b, want 000", cyc, got);
            end
        end
    end

    initial begin
        reset = 1'b1; shift = 1'b0; key = 4'h0;
        backspace = 1'b0; clear = 1'b0; commit = 1'b0;
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_st(last_stamp, 16'h0000, 3'd0);
        mon_en = 1'b1;

        // entry and rolling entry
        sh(4'd1, 16'h0001, 3'd1);
        sh(4'd2, 16'h0012, 3'd2);
        sh(4'd3, 16'h0123, 3'd3);
        sh(4'd0, 16'h1230, 3'd4);
        sh(4'd7, 16'h2307, 3'd4);
        sh(4'hB, 16'h2307, 3'd4);

        // backspace down to empty and one beyond
        bs(16'h0230, 3'd3);
        bs(16'h0023, 3'd2);
        bs(16'h0002, 3'd1);
        bs(16'h0000, 3'd0);
        bs(16'h0000, 3'd0);

        // accepted commit
        sh(4'd2, 16'h0002, 3'd1);
        sh(4'd3, 16'h0023, 3'd2);
        sh(4'd5, 16'h0235, 3'd3);
        sh(4'd9, 16'h2359, 3'd4);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cv_model = 16'h2359;
        expect_pulse(last_stamp, K_OK, 16'h2359);
        expect_st(last_stamp, 16'h0000, 3'd0);

        // rejected commits: hour 24, minute 60, short entry
        sh(4'd2, 16'h0002, 3'd1);
        sh(4'd4, 16'h0024, 3'd2);
        sh(4'd0, 16'h0240, 3'd3);
        sh(4'd0, 16'h2400, 3'd4);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_pulse(last_stamp, K_ERR, 16'h0000);
        expect_st(last_stamp, 16'h2400, 3'd4);
        clr();

        sh(4'd1, 16'h0001, 3'd1);
        sh(4'd2, 16'h0012, 3'd2);
        sh(4'd6, 16'h0126, 3'd3);
        sh(4'd0, 16'h1260, 3'd4);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_pulse(last_stamp, K_ERR, 16'h0000);
        expect_st(last_stamp, 16'h1260, 3'd4);
        clr();

        sh(4'd1, 16'h0001, 3'd1);
        sh(4'd2, 16'h0012, 3'd2);
        sh(4'd3, 16'h0123, 3'd3);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_pulse(last_stamp, K_ERR, 16'h0000);
        expect_st(last_stamp, 16'h0123, 3'd3);
        clr();

        // priority: commit over shift, backspace over shift, clear over shift
        sh(4'd1, 16'h0001, 3'd1);
        sh(4'd2, 16'h0012, 3'd2);
        sh(4'd3, 16'h0123, 3'd3);
        sh(4'd4, 16'h1234, 3'd4);
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        cv_model = 16'h1234;
        expect_pulse(last_stamp, K_OK, 16'h1234);
        expect_st(last_stamp, 16'h0000, 3'd0);
        sh(4'd6, 16'h0006, 3'd1);
        step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        expect_st(last_stamp, 16'h0000, 3'd0);
        sh(4'd4, 16'h0004, 3'd1);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        expect_st(last_stamp, 16'h0000, 3'd0);

        // inactivity timeout after 7 idle cycles
        sh(4'd5, 16'h0005, 3'd1);
        expect_st(last_stamp + 6, 16'h0005, 3'd1);
        expect_pulse(last_stamp + 7, K_TMO, 16'h0000);
        expect_st(last_stamp + 7, 16'h0000, 3'd0);
        repeat (9) @(posedge clock);

        // reset during a valid commit
        sh(4'd2, 16'h0002, 3'd1);
        sh(4'd3, 16'h0023, 3'd2);
        sh(4'd5, 16'h0235, 3'd3);
        sh(4'd9, 16'h2359, 3'd4);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cv_model = 16'h0000;
        expect_st(last_stamp, 16'h0000, 3'd0);
        expect_st(last_stamp + 2, 16'h0000, 3'd0);
        repeat (4) @(negedge clock);

        while (sq.size() > 0) begin
            me = sq.pop_front();
            checks++;
            errors++;
            $display("FAIL state_unchecked@%0d: got none, want kb=%h", me.stamp, me.kb);
        end
        while (pq.size() > 0) begin
            mp = pq.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_unseen@%0d: got none, want kind=%b", mp.stamp, mp.kind);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
